// File: rtl/teclado_pkg.sv
`default_nettype none
// ============================================================================
// Module      : teclado_pkg
// Description : Shared constants for the front-panel keypad event arbiter:
//               default PicoBlaze port addresses, the four event codes, the
//               presenter FSM state encoding, and the code/round-robin helpers.
// Revision    : 1.0 - initial release
// ============================================================================
package teclado_pkg;

    localparam logic [7:0] c_port_event  = 8'h03;
    localparam logic [7:0] c_port_status = 8'h04;

    localparam logic [7:0] c_code_aumenta   = 8'h04;
    localparam logic [7:0] c_code_disminuye = 8'h05;
    localparam logic [7:0] c_code_siguiente = 8'h06;
    localparam logic [7:0] c_code_anterior  = 8'h07;

    typedef enum logic {
        ST_IDLE    = 1'b0,
        ST_PRESENT = 1'b1
    } state_t;

    function automatic logic [7:0] event_code(input logic [1:0] idx);
        logic [7:0] code;
        case (idx)
            2'd0:    code = c_code_aumenta;
            2'd1:    code = c_code_disminuye;
            2'd2:    code = c_code_siguiente;
            default: code = c_code_anterior;
        endcase
        return code;
    endfunction

    // First set request strictly after 'last', wrapping 3->0. Scanning from
    // the farthest offset down lets the nearest hit overwrite earlier ones;
    // offset 4 wraps back onto 'last' itself, giving it lowest priority.
    function automatic logic [1:0] rr_pick(input logic [3:0] req, input logic [1:0] last);
        logic [1:0] idx;
        logic [1:0] pick;
        pick = last;
        for (int k = 4; k >= 1; k--) begin
            idx = last + 2'(k);
            if (req[idx]) pick = idx;
        end
        return pick;
    endfunction

endpackage
`default_nettype wire

// File: rtl/boton_debounce.sv
`default_nettype none
// ============================================================================
// Module      : boton_debounce
// Description : One raw push-button: 2-FF synchronizer, stability counter,
//               debounced level and a one-cycle press (0->1) pulse.
// Ports       : clk, reset (async, active-low), i_btn (raw, async),
//               o_rise (one-cycle pulse, coincident with the level rising)
// Revision    : 1.0 - initial release
// ============================================================================
module boton_debounce #(
    parameter int CNT_W           = 19,
    parameter int DEBOUNCE_CYCLES = 500000
) (
    input  logic clk,
    input  logic reset,
    input  logic i_btn,
    output logic o_rise
);

    localparam logic [CNT_W-1:0] c_cnt_last = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic             r_sync1;
    logic             r_sync2;
    logic [1:0]       r_sync_vld;
    logic             r_armed;
    logic             r_level;
    logic             r_rise;
    logic [CNT_W-1:0] r_cnt;
    logic             w_accept;

    assign w_accept = (r_sync2 != r_level) && (r_cnt == c_cnt_last);
    assign o_rise   = r_rise;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_sync1    <= 1'b0;
            r_sync2    <= 1'b0;
            r_sync_vld <= 2'b00;
            r_armed    <= 1'b0;
            r_level    <= 1'b0;
            r_rise     <= 1'b0;
            r_cnt      <= '0;
        end else begin
            r_sync1    <= i_btn;
            r_sync2    <= r_sync1;
            r_sync_vld <= {r_sync_vld[0], 1'b1};
            // A button held through reset must be seen released before any
            // press counts; the synchronizer's reset zeros are ignored.
            if (r_sync_vld[1] && !r_sync2) begin
                r_armed <= 1'b1;
            end
            r_rise <= w_accept && r_sync2 && r_armed;
            if (r_sync2 == r_level) begin
                r_cnt <= '0;
            end else if (r_cnt == c_cnt_last) begin
                r_level <= r_sync2;
                r_cnt   <= '0;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/teclado_event_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : teclado_event_arbiter
// Description : Debounces four front-panel buttons into press events, queues
//               one pending bit per button, and presents them one at a time to
//               the PicoBlaze through a round-robin arbiter and event port.
// Ports       : clk, reset (async, active-low)
//               aumenta/disminuye/siguiente/anterior - raw buttons
//               port_id, read_strobe - PicoBlaze input-port bus
//               in_port   - read data, combinational from port_id
//               interrupt - high while an event is presented
// Revision    : 1.0 - initial release
// ============================================================================
module teclado_event_arbiter
    import teclado_pkg::*;
#(
    parameter int         DEBOUNCE_CYCLES = 500000,
    parameter int         CNT_W           = 19,
    parameter logic [7:0] PORT_EVENT      = c_port_event,
    parameter logic [7:0] PORT_STATUS     = c_port_status
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       aumenta,
    input  logic       disminuye,
    input  logic       siguiente,
    input  logic       anterior,
    input  logic [7:0] port_id,
    input  logic       read_strobe,
    output logic [7:0] in_port,
    output logic       interrupt
);

    logic [3:0] w_btn;
    logic [3:0] w_rise;

    state_t     r_state;
    state_t     w_state_nxt;
    logic [3:0] r_pending;
    logic       r_overrun;
    logic       r_ev_valid;
    logic [7:0] r_ev_code;
    logic [1:0] r_last_grant;

    logic       w_ev_read;
    logic       w_st_read;
    logic       w_grant;
    logic [1:0] w_grant_idx;
    logic [3:0] w_clr;
    logic       w_ovr_set;

    assign w_btn = {anterior, siguiente, disminuye, aumenta};

    generate
        for (genvar gi = 0; gi < 4; gi++) begin : g_boton
            boton_debounce #(
                .CNT_W          (CNT_W),
                .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
            ) u_boton (
                .clk   (clk),
                .reset (reset),
                .i_btn (w_btn[gi]),
                .o_rise(w_rise[gi])
            );
        end
    endgenerate

    assign w_ev_read   = read_strobe && (port_id == PORT_EVENT) && (r_state == ST_PRESENT);
    assign w_st_read   = read_strobe && (port_id == PORT_STATUS);
    assign w_grant     = (r_state == ST_IDLE) && (|r_pending);
    assign w_grant_idx = rr_pick(r_pending, r_last_grant);
    assign w_clr       = w_grant ? (4'b0001 << w_grant_idx) : 4'b0000;
    // A press landing on the bit being granted this cycle re-arms it rather
    // than overrunning it.
    assign w_ovr_set   = |(w_rise & r_pending & ~w_clr);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            ST_IDLE:    if (|r_pending) w_state_nxt = ST_PRESENT;
            ST_PRESENT: if (w_ev_read)  w_state_nxt = ST_IDLE;
            default:    w_state_nxt = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_pending    <= 4'b0000;
            r_overrun    <= 1'b0;
            r_ev_valid   <= 1'b0;
            r_ev_code    <= 8'h00;
            r_last_grant <= 2'd3;
        end else begin
            r_pending <= (r_pending & ~w_clr) | w_rise;
            if (w_ovr_set) begin
                r_overrun <= 1'b1;
            end else if (w_st_read) begin
                r_overrun <= 1'b0;
            end
            if (w_grant) begin
                r_ev_valid   <= 1'b1;
                r_ev_code    <= event_code(w_grant_idx);
                r_last_grant <= w_grant_idx;
            end else if (w_ev_read) begin
                r_ev_valid <= 1'b0;
            end
        end
    end

    always_comb begin
        in_port = 8'h00;
        if (port_id == PORT_EVENT) begin
            in_port = r_ev_valid ? r_ev_code : 8'h00;
        end else if (port_id == PORT_STATUS) begin
            in_port = {r_ev_valid, r_overrun, 2'b00, r_pending};
        end
    end

    assign interrupt = r_ev_valid;

endmodule
`default_nettype wire
